// File: rtl/rot_step_sequencer.sv
// Sequencer around a single-pass 8-bit rotate stage: one pass per set bit of the amount, highest bit first.
// Build option ROT_ZERO_BYPASS_EN: a zero-amount request goes straight from IDLE to DONE.
module rot_step_sequencer #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dir,
  input  logic [AMT_W-1:0]  in_amt,
  output logic [DATA_W-1:0] rot_in,
  output logic              rot_dir,
  output logic [AMT_W-1:0]  rot_shift,
  input  logic [DATA_W-1:0] rot_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_acc;
  logic                r_dir;
  logic [AMT_W-1:0]    r_rem;
  logic [AMT_W-1:0]    w_top;
  logic [AMT_W-1:0]    w_rem_next;

  // Highest set bit first, matching the stage's own shift priority.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < AMT_W; i++) begin
      if (r_rem[i]) begin
        w_top    = '0;
        w_top[i] = 1'b1;
      end
    end
  end

  assign w_rem_next = r_rem & ~w_top;

  assign in_ready  = rst_n && (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_acc;
  assign rot_in    = r_acc;
  assign rot_dir   = r_dir;
  assign rot_shift = (r_state == STEP) ? w_top : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_dir   <= 1'b0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc <= in_data;
            r_dir <= in_dir;
            r_rem <= in_amt;
`ifdef ROT_ZERO_BYPASS_EN
            r_state <= (in_amt == '0) ? DONE : STEP;
`else
            r_state <= STEP;
`endif
          end
        end
        STEP: begin
          // A zero amount still takes one identity pass through the stage here.
          r_acc <= rot_out;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rot_step_sequencer.sv
// Bench for rot_step_sequencer: attached rotate-stage model, arithmetic reference model with
// per-cycle compare, and directed requests with literal expectations.
module tb_rot_step_sequencer;

`ifdef ROT_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dir;
  logic [2:0] in_amt;
  logic [7:0] rot_in;
  logic       rot_dir;
  logic [2:0] rot_shift;
  logic [7:0] rot_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  rot_step_sequencer #(.DATA_W(8), .AMT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_amt    (in_amt),
    .rot_in    (rot_in),
    .rot_dir   (rot_dir),
    .rot_shift (rot_shift),
    .rot_out   (rot_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain rotate by any amount 0..7.
  function automatic logic [7:0] rot8(input logic [7:0] d, input logic right, input int a);
    logic [15:0] t;
    int s;
    s = a % 8;
    if (right) begin
      t = {d, d} >> s;
      return t[7:0];
    end
    t = {d, d} << s;
    return t[15:8];
  endfunction

  // Rotate stage: one power-of-two rotation per pass, shift[2] over shift[1] over shift[0].
  always_comb begin
    int a;
    a = rot_shift[2] ? 4 : (rot_shift[1] ? 2 : (rot_shift[0] ? 1 : 0));
    rot_out = rot8(rot_in, rot_dir, a);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // n-th highest set bit of amt as a value (4/2/1), 0 if there is none.
  function automatic int nth_bit(input int amt, input int n);
    int k;
    k = 0;
    for (int b = 2; b >= 0; b--) begin
      if (amt[b]) begin
        if (k == n) return 1 << b;
        k++;
      end
    end
    return 0;
  endfunction

  function automatic int consumed(input int amt, input int passes);
    int s;
    s = 0;
    for (int i = 0; i < passes; i++) s += nth_bit(amt, i);
    return s;
  endfunction

  function automatic int npass_of(input int amt);
    if (amt == 0) return BYPASS ? 0 : 1;
    return $countones(amt);
  endfunction

  // Reference model: a request is a number of passes; DONE once all passes are made.
  logic       m_busy = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_dir  = 1'b0;
  int         m_amt  = 0;
  int         m_pass = 0;
  int         m_npass = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_pass  <= 0;
      m_npass <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy  <= 1'b1;
        m_data  <= in_data;
        m_dir   <= in_dir;
        m_amt   <= int'(in_amt);
        m_pass  <= 0;
        m_npass <= npass_of(int'(in_amt));
      end
    end else if (m_pass < m_npass) begin
      m_pass <= m_pass + 1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic m_done;
    logic [2:0] e_shift;
    m_done  = m_busy && (m_pass == m_npass);
    e_shift = (m_busy && !m_done) ? 3'(nth_bit(m_amt, m_pass)) : 3'b000;
    chk("cyc_in_ready", 32'(in_ready), 32'(rst_n && !m_busy));
    chk("cyc_busy", 32'(busy), 32'(m_busy));
    chk("cyc_out_valid", 32'(out_valid), 32'(m_done));
    chk("cyc_rot_shift", 32'(rot_shift), 32'(e_shift));
    if (m_busy) begin
      chk("cyc_rot_dir", 32'(rot_dir), 32'(m_dir));
      chk("cyc_acc", 32'(rot_in), 32'(rot8(m_data, m_dir, consumed(m_amt, m_pass))));
    end
    if (m_done) begin
      chk("cyc_out_data", 32'(out_data), 32'(rot8(m_data, m_dir, m_amt)));
    end
  end

  // One request with out_ready high; logs shift and acc per pass (oldest in the high bits).
  task automatic do_req(input logic [7:0] d, input logic dir, input logic [2:0] amt,
                        input logic [7:0] exp_out, input int exp_steps,
                        input logic [8:0] exp_sh, input logic [23:0] exp_acc, input string nm);
    logic [8:0]  sh;
    logic [23:0] ac;
    int steps;
    int bcnt;
    logic got;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_amt   = amt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hFF;
    in_dir   = ~dir;
    in_amt   = 3'd6;
    sh = '0;
    ac = '0;
    steps = 0;
    bcnt = 0;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      sh = {sh[5:0], rot_shift};
      ac = {ac[15:0], rot_in};
      steps++;
    end
    chk({nm, "_valid"}, 32'(got), 32'd1);
    chk({nm, "_steps"}, 32'(steps), 32'(exp_steps));
    chk({nm, "_shifts"}, 32'(sh), 32'(exp_sh));
    chk({nm, "_accs"}, 32'(ac), 32'(exp_acc));
    chk({nm, "_data"}, 32'(out_data), 32'(exp_out));
    chk({nm, "_dir"}, 32'(rot_dir), 32'(dir));
    chk({nm, "_busycyc"}, 32'(bcnt), 32'(exp_steps + 1));
    @(negedge clk);
    chk({nm, "_idle"}, 32'(busy), 32'd0);
    chk({nm, "_ready"}, 32'(in_ready), 32'd1);
    $display("req %s: data=%0h dir=%0d amt=%0d -> out=%0h steps=%0d", nm, d, dir, amt, out_data, steps);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_dir    = 1'b0;
    in_amt    = 3'd0;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rot_shift", 32'(rot_shift), 32'd0);
    chk("rst_acc", 32'(rot_in), 32'd0);
    chk("rst_dir", 32'(rot_dir), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    do_req(8'hB4, 1'b1, 3'd5, 8'hA5, 2, 9'b000_100_001, 24'h00_B4_4B, "right5");
    do_req(8'h81, 1'b0, 3'd3, 8'h0C, 2, 9'b000_010_001, 24'h00_81_06, "left3");
    do_req(8'h01, 1'b0, 3'd7, 8'h80, 3, 9'b100_010_001, 24'h01_10_40, "full7");
    do_req(8'h5A, 1'b1, 3'd0, 8'h5A, BYPASS ? 0 : 1, 9'b0, BYPASS ? 24'h0 : 24'h5A, "zero");
    do_req(8'h96, 1'b1, 3'd4, 8'h69, 1, 9'b000_000_100, 24'h00_00_96, "right4");

    // Backpressure: result held while a new request waits on in_valid.
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h3D;
    in_dir   = 1'b1;
    in_amt   = 3'd2;
    @(posedge clk);
    #1;
    in_data = 8'hC3;
    in_dir  = 1'b0;
    in_amt  = 3'd1;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("bp_valid", 32'(got), 32'd1);
    for (int c = 0; c < 4; c++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'h4F);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      if (c < 3) @(negedge clk);
    end
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("bp_next_valid", 32'(got), 32'd1);
    chk("bp_next_data", 32'(out_data), 32'h87);
    $display("req backpressure: first=4F held, second out=%0h", out_data);
    @(negedge clk);

    // Reset during the second pass of an amt 7 request.
    #1;
    in_valid = 1'b1;
    in_data  = 8'h01;
    in_dir   = 1'b0;
    in_amt   = 3'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_shift", 32'(rot_shift), 32'b010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_shift", 32'(rot_shift), 32'd0);
    chk("mid_rst_acc", 32'(rot_in), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", 32'(in_ready), 32'd1);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end
    $display("req reset_mid: aborted amt7 request, in_ready=%0d", in_ready);

    do_req(8'hC3, 1'b0, 3'd6, 8'hF0, 2, 9'b000_100_010, 24'h00_C3_3C, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rot_step_sequencer.md
Name: rot_step_sequencer

Overview:
- Sequencer upstream of, and wrapped around, the single-pass 8-bit rotate stage.
- The rotate stage applies only one power-of-two rotation per pass: 4, 2 or 1, with shift[2] taking priority over shift[1] over shift[0].
- This block accepts a full 3-bit rotate request and feeds the stage once per set bit of the amount, looping the stage's result back each cycle.
- It returns the finished word over a valid/ready handshake.

Parameters:
- DATA_W, 8, data width; must match the rotate stage; only 8 is supported.
- AMT_W, 3, rotate-amount width; one pass per bit.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  DATA_W  word to rotate.
- in_dir  input  1  1 = rotate right, 0 = rotate left (same encoding as the stage's direction).
- in_amt  input  AMT_W  rotate amount, 0..7.
- rot_in  output  DATA_W  to stage "in"; always equals the accumulator register.
- rot_dir  output  1  to stage "direction"; always equals the captured direction.
- rot_shift  output  AMT_W  to stage "shift"; one-hot or zero.
- rot_out  input  DATA_W  from stage "out"; combinational return in the same cycle.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DATA_W  rotated result; equals the accumulator.
- busy  output  1  state != IDLE.

Behaviour:
- Registers: state (IDLE, STEP, DONE), acc[DATA_W], dir, rem[AMT_W].
- Reset (rst_n low, asynchronous):
  - state = IDLE; acc = 0; dir = 0; rem = 0.
  - out_valid = 0, busy = 0, rot_shift = 0, in_ready = 0.
  - in_ready is gated by rst_n and goes to 1 in the first cycle after release.
- in_ready = rst_n && state == IDLE.
- IDLE, on in_valid && in_ready at an edge:
  - acc <= in_data, dir <= in_dir, rem <= in_amt.
  - Go to STEP (zero-amount handling is covered under Optional Feature).
- STEP:
  - rot_shift = one-hot of the highest set bit of rem; 000 if rem == 0.
  - At the edge: acc <= rot_out, and that bit is cleared in rem.
  - If the post-clear rem == 0, go to DONE; otherwise stay in STEP.
  - The highest-bit-first order matches the stage's priority, so only one stage bit is ever active per pass.
- DONE:
  - out_valid = 1; out_data = acc, held stable while out_ready = 0.
  - On out_ready, go to IDLE at the edge. No accept in the same cycle; earliest next accept is the following cycle.
- rot_shift = 000 in IDLE and DONE, so the stage is a pass-through.
- Latency:
  - out_valid is first seen k cycles after the accept edge, where k = popcount(in_amt), minimum 1.
  - Throughput: one request per k + 2 cycles when out_ready is held high.
- Boundary cases:
  - amt = 7: 3 passes (4, 2, 1).
  - amt = 4, 2 or 1: exactly 1 pass.
  - The direction used for every pass is the captured dir; later changes on in_dir are ignored.
  - in_valid while busy: in_ready is 0, so the request is not captured.
  - Inputs are ignored outside an IDLE handshake.
- Reset mid-operation: all registers clear immediately and the partial result is discarded; no out_valid is produced for the aborted request.

Optional Feature:
- Macro: ROT_ZERO_BYPASS_EN.
- Defined: a request with in_amt == 0 goes IDLE -> DONE directly at the accept edge. acc = in_data, and out_valid is seen in the cycle right after the accept edge. The stage is never exercised (rot_shift stays 000).
- Not defined: in_amt == 0 spends one STEP cycle with rot_shift = 000 (stage is identity), acc <= rot_out, then DONE. Latency is 1, uniform with the one-bit amounts.
- All other behaviour is identical in both builds.

Test Plan:
- Right rotate: in_data 8'hB4, in_dir 1, in_amt 5 (stage model attached).
  - Required: rot_shift 100 then 001; acc 8'h4B then 8'hA5.
  - out_data 8'hA5, out_valid 2 cycles after the accept edge.
- Left rotate: in_data 8'h81, in_dir 0, in_amt 3.
  - Required: passes 010 then 001 giving 8'h06 then 8'h0C.
  - out_data 8'h0C.
- Full amount: in_data 8'h01, in_dir 0, in_amt 7.
  - Required: 3 passes (100, 010, 001); out_data 8'h80; busy high for 4 cycles including DONE.
- Zero amount: in_data 8'h5A, in_amt 0.
  - Required: out_data 8'h5A in both builds.
  - Without the macro: one STEP with rot_shift 000, latency 1.
  - With ROT_ZERO_BYPASS_EN: no STEP cycle.
- Backpressure and request blocking:
  - Stimulus: out_ready held low 4 cycles in DONE while in_valid is asserted with new data.
  - Required: out_data and out_valid stable, in_ready 0, new data not captured.
  - After out_ready rises: IDLE, then the new request is accepted.
- Reset mid-operation: rst_n pulsed low during the second STEP of an amt 7 request.
  - Required: immediate out_valid 0, busy 0, rot_shift 000.
  - After release: in_ready 1 and no stale result.
